led_tick_scheduler: RTL and testbench
=====================================

Name: led_tick_scheduler

Overview:
Shares one synchronous prescaler between NUM_CH LED channels. Each channel runs its own sequence (off, on, blink or counted burst) from a per-channel configuration, with all timing counted in shared prescaler ticks. The block replaces per-LED divider chains with a single system-clock domain: no derived clocks, and every flop clocks on clk. It sits between a control source that issues cfg writes and the board LED pins.

Parameters:
NUM_CH, 2, number of LED channels (1..16)
PRESCALE_W, 16, width of the prescaler counter and of the prescale input
PERIOD_W, 10, width of the per-channel phase length, counted in ticks
CH_W, $clog2(NUM_CH) (minimum 1), width of the cfg_ch input

Ports:
clk  in  1  system clock; all logic clocks on its rising edge
rst  in  1  asynchronous active-low reset
prescale  in  PRESCALE_W  tick divisor; a tick fires every prescale+1 cycles
tick  out  1  one-cycle tick strobe, registered
cfg_valid  in  1  configuration write request
cfg_ready  out  1  block can accept a cfg write
cfg_ch  in  CH_W  target channel
cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
cfg_period  in  PERIOD_W  phase length in ticks; 0 is treated as 1
cfg_count  in  4  number of BURST pulses
led  out  NUM_CH  LED drive, registered
busy  out  NUM_CH  channel is in BLINK or in an unfinished BURST

Behaviour:
- Reset (rst=0, asynchronous):
  - pcnt=0, tick=0, led=0, busy=0, cfg_ready=1.
  - All channels go to mode OFF, state IDLE; phase and pulse counters are cleared.
  - Reset mid-sequence aborts the sequence with no further LED activity.
- Prescaler:
  - pcnt increments every cycle.
  - If pcnt >= prescale, then pcnt<=0 and tick<=1 on the same edge; otherwise tick<=0.
  - prescale=0 gives tick=1 every cycle.
  - prescale is read live. If it is lowered below pcnt, the next edge wraps and ticks.
- Config handshake:
  - A write is accepted on the edge where cfg_valid && cfg_ready.
  - cfg_ready<=0 on that edge and returns to 1 on the next edge, so at most one accept every 2 cycles.
  - If cfg_ch >= NUM_CH, the write is accepted and ignored.
- Channel FSM, states IDLE, ON_PH, OFF_PH. All updates below happen on the accept edge (latency 1 edge):
  - OFF: IDLE, led=0, busy=0.
  - ON: IDLE, led=1, busy=0.
  - BLINK: ON_PH, led=1, busy=1, phase counter=0.
  - BURST with count>0: ON_PH, led=1, busy=1, phase=0, remaining=count.
  - BURST with count=0: IDLE, led=0, busy=0.
- Phase advance, only on tick edges:
  - phase<=phase+1 each tick.
  - When phase reaches eff_period-1 on a tick, phase<=0 and the state changes.
  - ON_PH goes to OFF_PH with led=0. In BURST, remaining is decremented at this point.
  - OFF_PH: in BLINK, go to ON_PH with led=1.
  - OFF_PH: in BURST with remaining>0, go to ON_PH with led=1.
  - OFF_PH: in BURST with remaining=0, go to IDLE with led=0 and busy=0 on the same edge.
- eff_period = (cfg_period==0) ? 1 : cfg_period. It is latched at accept.
- Simultaneous cfg accept and tick on the same channel: the cfg wins, and that tick is not counted for the channel. Other channels still advance.
- Reconfiguring mid-sequence restarts the channel from the new mode's entry state. The prescaler is never reset by a cfg write.
- Blink full cycle = 2*eff_period ticks. Burst duration = 2*count*eff_period ticks.

Test Plan:
- Prescaler:
  - Release reset with prescale=3: tick is high on cycles 4, 8, 12… after release, one cycle wide.
  - Change prescale to 0 while pcnt=2: tick on the next edge, then every cycle.
- Handshake:
  - Hold cfg_valid=1 for 4 cycles: exactly 2 accepts, and cfg_ready toggles 1,0,1,0.
  - Write with cfg_ch=3 when NUM_CH=2: accepted, and no led or busy change.
- BLINK, prescale=0, ch0, period=2: led0 reads 1,1,0,0,1,1… from the accept edge onward, and busy0 stays 1.
- BURST:
  - prescale=0, ch1, count=3, period=1: led1 reads 1,0,1,0,1,0, then busy1 falls on the same edge led1 settles at 0, and led1 stays 0.
  - count=0: led1=0 and busy1=0 immediately.
  - period=0: behaves identically to period=1.
- Reconfig and reset:
  - Mid-BURST, write ON to the same channel: led=1 and busy=0 after the accept edge, and remaining pulses are abandoned.
  - Assert rst asynchronously mid-blink: led, busy and tick go to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/led_tick_scheduler.sv
// LED sequencer: one shared prescaler times per-channel off/on/blink/burst sequences.
// Latency: a cfg write takes effect on its accept edge; tick, led and busy are registered.
// Backpressure: cfg_ready drops for one cycle after every accept (one write per 2 cycles).
module led_tick_scheduler #(
    parameter int NUM_CH     = 2,
    parameter int PRESCALE_W = 16,
    parameter int PERIOD_W   = 10,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic [PERIOD_W-1:0]   cfg_period,
    input  logic [3:0]            cfg_count,
    output logic [NUM_CH-1:0]     led,
    output logic [NUM_CH-1:0]     busy
);

    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_t;
    typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH} st_t;

    localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);

    logic [PRESCALE_W-1:0] pcnt;
    logic                  tick_now;
    logic                  cfg_acc;
    logic                  ch_ok;

    // prescale is compared live, so lowering it below pcnt wraps on the next edge
    assign tick_now = (pcnt >= prescale);
    assign cfg_acc  = cfg_valid && cfg_ready;
    assign ch_ok    = (32'(cfg_ch) < 32'(NUM_CH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt      <= '0;
            tick      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            if (tick_now) begin
                pcnt <= '0;
                tick <= 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
                tick <= 1'b0;
            end
            cfg_ready <= !cfg_acc;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_t               mode;
        st_t                 st;
        logic [PERIOD_W-1:0] phase;
        logic [PERIOD_W-1:0] per;
        logic [3:0]          rem;
        logic                led_q;
        logic                busy_q;
        logic                hit;

        assign hit     = cfg_acc && ch_ok && (cfg_ch == CH_W'(i));
        assign led[i]  = led_q;
        assign busy[i] = busy_q;

        // a write on a tick edge takes priority, so that tick is not counted here
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode   <= M_OFF;
                st     <= IDLE;
                phase  <= '0;
                per    <= PER_ONE;
                rem    <= '0;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
            end else if (hit) begin
                mode  <= mode_t'(cfg_mode);
                phase <= '0;
                per   <= (cfg_period == '0) ? PER_ONE : cfg_period;
                rem   <= cfg_count;
                case (mode_t'(cfg_mode))
                    M_OFF: begin
                        st <= IDLE; led_q <= 1'b0; busy_q <= 1'b0;
                    end
                    M_ON: begin
                        st <= IDLE; led_q <= 1'b1; busy_q <= 1'b0;
                    end
                    M_BLINK: begin
                        st <= ON_PH; led_q <= 1'b1; busy_q <= 1'b1;
                    end
                    default: begin
                        if (cfg_count != 4'd0) begin
                            st <= ON_PH; led_q <= 1'b1; busy_q <= 1'b1;
                        end else begin
                            st <= IDLE; led_q <= 1'b0; busy_q <= 1'b0;
                        end
                    end
                endcase
            end else if (tick_now && st != IDLE) begin
                if (phase == per - PER_ONE) begin
                    phase <= '0;
                    if (st == ON_PH) begin
                        st    <= OFF_PH;
                        led_q <= 1'b0;
                        if (mode == M_BURST) rem <= rem - 4'd1;
                    end else if (mode == M_BLINK || rem != 4'd0) begin
                        st    <= ON_PH;
                        led_q <= 1'b1;
                    end else begin
                        st     <= IDLE;
                        led_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end else begin
                    phase <= phase + PER_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_tick_scheduler.sv
// Self-checking bench for led_tick_scheduler: directed plan items plus randomized traffic
// compared every cycle against a tick-count model of each channel's sequence.
module tb_led_tick_scheduler;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] prescale = 16'd3;
    logic        tick;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [9:0]  cfg_period = '0;
    logic [3:0]  cfg_count = '0;
    logic [1:0]  led;
    logic [1:0]  busy;

    int n_chk = 0;
    int n_fail = 0;

    led_tick_scheduler #(
        .NUM_CH(NCH), .PRESCALE_W(16), .PERIOD_W(10), .CH_W(2)
    ) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .tick(tick),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is described by its mode, latched period and count, and the
    // number of ticks it has seen since its last accepted write.
    int m_pc = 0;
    bit m_tick = 0;
    bit m_rdy = 1;
    int m_mode [NCH];
    int m_n    [NCH];
    int m_p    [NCH];
    int m_c    [NCH];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 0; m_tick = 0; m_rdy = 1;
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0; m_n[c] = 0; m_p[c] = 1; m_c[c] = 0;
            end
        end else begin
            bit tk;
            bit acc;
            tk  = (m_pc >= int'(prescale));
            acc = cfg_valid && m_rdy;
            for (int c = 0; c < NCH; c++) begin
                if (acc && int'(cfg_ch) == c) begin
                    m_mode[c] = int'(cfg_mode);
                    m_p[c]    = (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_c[c]    = int'(cfg_count);
                    m_n[c]    = 0;
                end else if (tk) begin
                    m_n[c]++;
                end
            end
            m_pc   = tk ? 0 : m_pc + 1;
            m_tick = tk;
            m_rdy  = !acc;
        end
    end

    function automatic logic [1:0] exp_busy_led(input int mode, input int n, input int p, input int cnt);
        case (mode)
            0: return 2'b00;
            1: return 2'b01;
            2: return {1'b1, 1'((n / p) % 2 == 0)};
            default: begin
                if (n >= 2 * cnt * p) return 2'b00;
                return {1'b1, 1'((n / p) % 2 == 0)};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            logic [1:0] el;
            logic [1:0] eb;
            logic [1:0] bl;
            for (int c = 0; c < NCH; c++) begin
                bl    = exp_busy_led(m_mode[c], m_n[c], m_p[c], m_c[c]);
                el[c] = bl[0];
                eb[c] = bl[1];
            end
            chk("model_tick", tick, m_tick);
            chk("model_cfg_ready", cfg_ready, m_rdy);
            chk("model_led", led, el);
            chk("model_busy", busy, eb);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int ch, input int mode, input int per, input int cnt);
        int w;
        w = 0;
        while (!cfg_ready && w < 4) begin
            step();
            w++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        cfg_ch     = 2'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = 10'(per);
        cfg_count  = 4'(cnt);
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] blink_exp;
        logic [7:0] burst_led;
        logic [7:0] burst_busy;
        int acc_cnt;
        blink_exp  = 6'b110011;
        burst_led  = 8'b10101000;
        burst_busy = 8'b11111100;

        #23;
        chk("rst_tick", tick, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        @(posedge clk); #2;
        rst = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("tick_prescale3", tick, (c % 4 == 0) ? 1 : 0);
        end
        step(); step();
        chk("tick_before_drop", tick, 0);
        prescale = 16'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("tick_prescale0", tick, 1);
        end

        cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_period = 10'd1; cfg_count = 4'd0;
        cfg_valid = 1'b1;
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            chk("ready_toggle", cfg_ready, (k % 2 == 0) ? 1 : 0);
            if (cfg_ready) acc_cnt++;
            step();
        end
        cfg_valid = 1'b0;
        chk("accept_count", acc_cnt, 2);
        step();
        chk("on_led", led, 2'b01);
        chk("on_busy", busy, 2'b00);

        cfg_write(3, 1, 1, 0);
        chk("bad_ch_led", led, 2'b01);
        chk("bad_ch_busy", busy, 2'b00);
        step(); step();
        chk("bad_ch_led_later", led, 2'b01);

        cfg_write(0, 2, 2, 0);
        for (int k = 0; k < 6; k++) begin
            chk("blink_led0", led[0], blink_exp[5-k]);
            chk("blink_busy0", busy[0], 1);
            step();
        end

        cfg_write(1, 3, 1, 3);
        for (int k = 0; k < 8; k++) begin
            chk("burst_led1", led[1], burst_led[7-k]);
            chk("burst_busy1", busy[1], burst_busy[7-k]);
            step();
        end

        cfg_write(1, 3, 2, 2);
        step();
        chk("burst_pre_busy1", busy[1], 1);
        cfg_write(1, 3, 5, 0);
        chk("burst_cnt0_led1", led[1], 0);
        chk("burst_cnt0_busy1", busy[1], 0);

        step();
        cfg_write(1, 3, 0, 3);
        for (int k = 0; k < 8; k++) begin
            chk("burst_p0_led1", led[1], burst_led[7-k]);
            chk("burst_p0_busy1", busy[1], burst_busy[7-k]);
            step();
        end

        cfg_write(1, 3, 3, 4);
        repeat (4) step();
        chk("reconf_pre_busy1", busy[1], 1);
        cfg_write(1, 1, 0, 0);
        chk("reconf_led1", led[1], 1);
        chk("reconf_busy1", busy[1], 0);
        repeat (30) step();
        chk("reconf_led1_later", led[1], 1);
        chk("reconf_busy1_later", busy[1], 0);

        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) prescale = 16'($urandom_range(0, 6));
            cfg_valid  = ($urandom_range(0, 9) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = 10'($urandom_range(0, 4));
            cfg_count  = 4'($urandom_range(0, 5));
            step();
        end
        cfg_valid = 1'b0;

        prescale = 16'd0;
        step(); step();
        cfg_write(0, 2, 3, 0);
        step();
        chk("pre_rst_led0", led[0], 1);
        chk("pre_rst_tick", tick, 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_tick", tick, 0);
        chk("async_rst_led", led, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", cfg_ready, 1);
        #10 rst = 1'b1;
        repeat (3) step();
        chk("post_rst_led", led, 0);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
